// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions: pointer struct and next-pointer step.
// Index wraps at depth-1 and toggles the phase bit, so any depth >= 2 works.
package fifo_pkg;

    localparam int PTR_MAX_W = 16;

    typedef struct packed {
        logic                 phase;
        logic [PTR_MAX_W-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_next(input ptr_t p, input int unsigned depth);
        ptr_t n;
        if (32'(p.idx) == depth - 1) begin
            n.idx   = '0;
            n.phase = ~p.phase;
        end else begin
            n.idx   = p.idx + PTR_MAX_W'(1);
            n.phase = p.phase;
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: index 0..DEPTH-1 plus phase bit, increment and sync clear.
// Ports: clk, rst_n, clr_i, inc_i -> idx_o, phase_o.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] idx_o,
    output logic          phase_o
);

    logic [AW-1:0] idx_q, idx_d;
    logic          phase_q, phase_d;
    ptr_t          cur, nxt;

    always_comb begin
        cur.phase = phase_q;
        cur.idx   = PTR_MAX_W'(idx_q);
        nxt       = ptr_next(cur, DEPTH);
        idx_d     = idx_q;
        phase_d   = phase_q;
        if (clr_i) begin
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (inc_i) begin
            idx_d   = AW'(nxt.idx);
            phase_d = nxt.phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign idx_o   = idx_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FWFT FIFO, any depth, valid/ready, programmable watermarks,
// sync flush, sticky overflow/underflow. Ports: write side (data_i,
// wr_valid_i, wr_ready_o), read side (data_o, rd_valid_o, rd_ready_i),
// thresholds, status (full/empty/almost/counter), error flags + err_clr_i.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 32,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    input  logic [ADDR_WIDTH:0]   afull_thr_i,
    input  logic [ADDR_WIDTH:0]   aempty_thr_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   counter_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  err_clr_i
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic                  wr_ph, rd_ph;
    logic                  full, empty;
    logic [CW-1:0]         count;
    logic                  wr_acc, rd_acc;
    logic                  ovf_q, ovf_d, unf_q, unf_d;

    fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush_i),
        .inc_i   (wr_acc),
        .idx_o   (wr_idx),
        .phase_o (wr_ph)
    );

    fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (flush_i),
        .inc_i   (rd_acc),
        .idx_o   (rd_idx),
        .phase_o (rd_ph)
    );

    always_comb begin
        empty = (wr_idx == rd_idx) && (wr_ph == rd_ph);
        full  = (wr_idx == rd_idx) && (wr_ph != rd_ph);
        if (wr_ph == rd_ph) begin
            count = CW'(wr_idx) - CW'(rd_idx);
        end else begin
            count = CW'(FIFO_DEPTH) + CW'(wr_idx) - CW'(rd_idx);
        end
        // Flush drops both transfers that cycle.
        wr_acc = wr_valid_i && !full && !flush_i;
        rd_acc = rd_ready_i && !empty && !flush_i;
        // A new error beats a same-cycle clear; flush beats everything.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (flush_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (wr_valid_i && full) begin
                ovf_d = 1'b1;
            end else if (err_clr_i) begin
                ovf_d = 1'b0;
            end
            if (rd_ready_i && empty) begin
                unf_d = 1'b1;
            end else if (err_clr_i) begin
                unf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    assign data_o         = empty ? '0 : mem_q[rd_idx];
    assign wr_ready_o     = !full;
    assign rd_valid_o     = !empty;
    assign full_o         = full;
    assign empty_o        = empty;
    assign counter_o      = count;
    assign almost_full_o  = (count >= afull_thr_i);
    assign almost_empty_o = (count <= aempty_thr_i);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Self-checking bench for fifo_prog (depth 5) against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_fifo_prog;

    localparam int DW = 8;
    localparam int D  = 5;
    localparam int AW = $clog2(D);

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic [DW-1:0] data_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [DW-1:0] data_o;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [AW:0]   afull_thr_i;
    logic [AW:0]   aempty_thr_i;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic [AW:0]   counter_o;
    logic          overflow_o;
    logic          underflow_o;
    logic          err_clr_i;

    fifo_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .data_i         (data_i),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .data_o         (data_o),
        .rd_valid_o     (rd_valid_o),
        .rd_ready_i     (rd_ready_i),
        .afull_thr_i    (afull_thr_i),
        .aempty_thr_i   (aempty_thr_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .counter_o      (counter_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .err_clr_i      (err_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain queue of entries plus two flags.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    int            n_cmp;
    int            n_err;
    int            max_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int          n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk({tag, ".cnt"},   32'(counter_o), 32'(n));
        chk({tag, ".full"},  32'(full_o), 32'(n == D));
        chk({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
        chk({tag, ".wrdy"},  32'(wr_ready_o), 32'(n != D));
        chk({tag, ".rval"},  32'(rd_valid_o), 32'(n != 0));
        chk({tag, ".data"},  32'(data_o), 32'(head));
        chk({tag, ".afull"}, 32'(almost_full_o),
            32'(n >= int'(afull_thr_i)));
        chk({tag, ".aempty"}, 32'(almost_empty_o),
            32'(n <= int'(aempty_thr_i)));
        chk({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
        chk({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
        if (n > max_cnt) max_cnt = n;
    endtask

    // One clock: drive, advance model on pre-edge state, check after edge.
    task automatic cyc(input string tag, input bit wv, input logic [DW-1:0] wd,
                       input bit rr, input bit fl, input bit ec);
        bit was_full;
        bit was_empty;
        wr_valid_i = wv;
        data_i     = wd;
        rd_ready_i = rr;
        flush_i    = fl;
        err_clr_i  = ec;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (fl) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (rr && !was_empty) void'(q.pop_front());
            if (wv && !was_full) q.push_back(wd);
            if (wv && was_full) m_ovf = 1;
            else if (ec) m_ovf = 0;
            if (rr && was_empty) m_unf = 1;
            else if (ec) m_unf = 0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        max_cnt      = 0;
        m_ovf        = 0;
        m_unf        = 0;
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        data_i       = '0;
        wr_valid_i   = 1'b0;
        rd_ready_i   = 1'b0;
        err_clr_i    = 1'b0;
        afull_thr_i  = 4'd3;
        aempty_thr_i = 4'd1;
        #1;
        check_all("reset");
        afull_thr_i = 4'd0;
        #1;
        chk("reset.afull_thr0", 32'(almost_full_o), 32'd1);
        afull_thr_i = 4'd3;
        #10;
        rst_n = 1'b1;

        // Fill 0x11..0x15, then overflow with 0x16, then drain.
        for (int i = 0; i < D; i++) cyc("fill", 1, 8'(8'h11 + i), 0, 0, 0);
        chk("fill.full", 32'(full_o), 32'd1);
        chk("fill.cnt5", 32'(counter_o), 32'd5);
        cyc("ovf6", 1, 8'h16, 0, 0, 0);
        chk("ovf6.flag", 32'(overflow_o), 32'd1);
        for (int i = 0; i < D; i++) begin
            chk("drain.head", 32'(data_o), 32'(8'h11 + i));
            cyc("drain", 0, 8'h00, 1, 0, 0);
        end
        chk("drain.empty", 32'(empty_o), 32'd1);
        chk("drain.data0", 32'(data_o), 32'd0);
        cyc("clr", 0, 8'h00, 0, 0, 1);

        // Interleaved traffic across two wraps of the index.
        for (int i = 0; i < 18; i++) begin
            cyc("wrap", (i % 3) != 2, 8'(8'h30 + i), (i % 2) == 1, 0, 0);
        end
        while (q.size() < D) cyc("wrapfill", 1, 8'h5a, 0, 0, 0);

        // Full: simultaneous write and read.
        cyc("fullrw", 1, 8'h77, 1, 0, 0);
        chk("fullrw.ovf", 32'(overflow_o), 32'd1);
        chk("fullrw.cnt4", 32'(counter_o), 32'd4);
        cyc("clr2", 0, 8'h00, 0, 0, 1);
        while (q.size() > 0) cyc("drain2", 0, 8'h00, 1, 0, 0);

        // Empty: simultaneous write and read.
        cyc("emptyrw", 1, 8'hA5, 1, 0, 0);
        chk("emptyrw.unf", 32'(underflow_o), 32'd1);
        chk("emptyrw.cnt1", 32'(counter_o), 32'd1);
        chk("emptyrw.data", 32'(data_o), 32'hA5);
        cyc("clr3", 0, 8'h00, 1, 0, 1);
        // New underflow alongside a clear keeps the flag set.
        cyc("unf_vs_clr", 0, 8'h00, 1, 0, 1);
        chk("unf_vs_clr.flag", 32'(underflow_o), 32'd1);
        cyc("clr4", 0, 8'h00, 0, 0, 1);

        // Watermarks at counts 0..4 (afull 3, aempty 1).
        for (int i = 0; i < 4; i++) cyc("wm", 1, 8'(8'h60 + i), 0, 0, 0);
        while (q.size() > 0) cyc("wmdrain", 0, 8'h00, 1, 0, 0);

        // Flush with 3 entries and a pending write.
        cyc("preunf", 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("pflush", 1, 8'(8'h90 + i), 0, 0, 0);
        cyc("flush", 1, 8'hEE, 1, 1, 0);
        chk("flush.cnt", 32'(counter_o), 32'd0);
        chk("flush.unf", 32'(underflow_o), 32'd0);
        cyc("postflush", 0, 8'h00, 0, 0, 0);

        // Async reset mid-burst.
        for (int i = 0; i < 3; i++) cyc("burst", 1, 8'(8'hC0 + i), 0, 0, 0);
        cyc("burstovf", 1, 8'hC3, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        #1;
        check_all("async_rst");
        #3;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ((i % 25) == 0) begin
                afull_thr_i  = 4'($urandom_range(0, 6));
                aempty_thr_i = 4'($urandom_range(0, 6));
            end
            cyc("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 31) == 0,
                $urandom_range(0, 15) == 0);
        end
        chk("max_cnt", 32'(max_cnt <= D), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_prog.md
# fifo_prog

Synchronous single-clock FIFO, next generation of the team's register-array FIFO. Adds:
- arbitrary (non-power-of-two) depth,
- valid/ready handshakes on both sides,
- runtime-programmable almost-full/almost-empty thresholds,
- synchronous flush,
- sticky overflow/underflow error flags.

It sits between producer/consumer blocks (UART/SPI byte streams, command queues) wherever backpressure and watermark interrupts are needed.

## Interface
- DATA_WIDTH, 8, payload width in bits.
- FIFO_DEPTH, 32, number of entries; any integer ≥ 2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), derived; not to be overridden.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of pointers and error flags.
- data_i  in  DATA_WIDTH  write data.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  space available (= !full_o).
- data_o  out  DATA_WIDTH  head entry (first-word-fall-through); 0 when empty.
- rd_valid_o  out  1  data available (= !empty_o).
- rd_ready_i  in  1  consumer pops head.
- afull_thr_i  in  ADDR_WIDTH+1  almost-full watermark.
- aempty_thr_i  in  ADDR_WIDTH+1  almost-empty watermark.
- full_o, empty_o  out  1  occupancy == FIFO_DEPTH / == 0.
- almost_full_o  out  1  counter_o ≥ afull_thr_i.
- almost_empty_o  out  1  counter_o ≤ aempty_thr_i.
- counter_o  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- overflow_o, underflow_o  out  1  sticky error flags.
- err_clr_i  in  1  clears sticky flags.

## Operation
- Pointers: index 0..FIFO_DEPTH-1 plus a phase bit.
  - Increment at index FIFO_DEPTH-1 returns the index to 0 and toggles the phase bit.
  - Never modulo 2^ADDR_WIDTH.
- Status decode:
  - empty = indices equal and phases equal.
  - full = indices equal and phases differ.
  - counter = wr_idx - rd_idx when phases are equal, FIFO_DEPTH + wr_idx - rd_idx otherwise; computed at ADDR_WIDTH+1 bits.
- Write accepted when wr_valid_i & wr_ready_o: data stored at wr_idx, write pointer advances.
- Read accepted when rd_valid_o & rd_ready_i: read pointer advances.
- data_o is combinational from the array at rd_idx, forced to 0 when empty.
- Simultaneous accepted read and write: both pointers advance, counter unchanged.
- When full: a read is accepted and the write is rejected, because ready is evaluated on pre-edge state.
- When empty: a write is accepted and the read is rejected.
- Rejected write (wr_valid_i & full_o) sets overflow_o; the array and pointers are untouched.
- Rejected read (rd_ready_i & empty_o) sets underflow_o.
- err_clr_i clears both flags; a same-cycle new error wins (flag stays 1).
- flush_i has priority over everything:
  - both pointers go to 0, both error flags clear;
  - writes and reads that cycle are dropped and raise no error flag.
- Array contents are not reset; only pointers and flags are.
- Thresholds are sampled combinationally.
  - afull_thr_i = 0 forces almost_full_o = 1.
  - aempty_thr_i ≥ FIFO_DEPTH forces almost_empty_o = 1.

## Timing
- Reset values:
  - empty_o = 1, rd_valid_o = 0, data_o = 0.
  - full_o = 0, wr_ready_o = 1.
  - counter_o = 0, overflow_o = underflow_o = 0.
  - almost_empty_o = 1, almost_full_o = (afull_thr_i == 0).
- Write-to-read latency is 1 cycle: data written at edge N is on data_o with rd_valid_o = 1 after edge N.
- All status outputs reflect post-edge pointer state.
  - No combinational path from wr_valid_i/rd_ready_i to any output.
  - Threshold inputs are the only input-to-output combinational path.
- Reset asserted mid-transfer: pointers and flags clear immediately (asynchronously); the in-flight write is lost.
- Error flags assert the cycle after the offending edge.

## Structure
- Pointer width and the next-pointer function (index wrap at FIFO_DEPTH-1, phase toggle) live in the shared fifo_pkg include, for reuse by future FIFO variants.
- One sub-module: fifo_ptr. It holds index, phase, increment enable and synchronous clear, and is instantiated for the read and write pointers.
- Array, status decode and flag logic stay in fifo_prog.

## Test plan
- DEPTH=5, write 0x11..0x15 with no reads:
  - full_o = 1 and counter_o = 5 after the 5th edge;
  - a 6th write of 0x16 is rejected and overflow_o = 1;
  - reads then return 0x11..0x15 in order, then empty_o = 1 and data_o = 0.
- DEPTH=5, 12 writes interleaved with reads across two wrap-arounds: data order is preserved, counter_o never exceeds 5, and full/empty decode is correct at indices 4→0.
- At counter_o = 5, assert write and read together: read of the head is accepted, write rejected, overflow_o = 1, counter_o = 4.
- At counter_o = 0, assert write 0xA5 and read together: write accepted, underflow_o = 1, counter_o = 1, data_o = 0xA5 next cycle.
- afull_thr_i = 3, aempty_thr_i = 1:
  - almost_empty_o is 1 at counts 0–1 and 0 at count 2;
  - almost_full_o rises exactly at count 3.
- flush_i with 3 entries and wr_valid_i high: counter_o = 0, empty_o = 1, flags clear, and the written data does not appear.
- Async rst_n low mid-burst: all outputs take their reset values without waiting for a clock edge.
